// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell, LSB first, one bit per clock.
// Start/busy/done handshake; difference and borrow_out update only when an operation completes.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             borrow_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res_sr;
  logic             r_borrow;
  logic [CNT_W-1:0] r_count;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_difference;
  logic             r_borrow_out;

  logic             w_a;
  logic             w_b;
  logic             w_d;
  logic             w_br_next;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  assign w_a       = r_a_sr[0];
  assign w_b       = r_b_sr[0];
  assign w_d       = w_a ^ w_b ^ r_borrow;
  assign w_br_next = (~w_a & w_b) | (~(w_a ^ w_b) & r_borrow);
  assign w_last    = (r_count == LAST_BIT);

  // New difference bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  always_comb begin
    w_res_next            = r_res_sr >> 1;
    w_res_next[WIDTH-1]   = w_d;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = SHIFT;
        end else begin
          w_state_next = IDLE;
        end
      end
      SHIFT: begin
        if (w_last) begin
          w_state_next = DONE;
        end else begin
          w_state_next = SHIFT;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Operand/result shifting, borrow, bit counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_sr       <= {WIDTH{1'b0}};
      r_b_sr       <= {WIDTH{1'b0}};
      r_res_sr     <= {WIDTH{1'b0}};
      r_borrow     <= 1'b0;
      r_count      <= {CNT_W{1'b0}};
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_difference <= {WIDTH{1'b0}};
      r_borrow_out <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_sr   <= minuend;
            r_b_sr   <= subtrahend;
            r_res_sr <= {WIDTH{1'b0}};
            r_borrow <= 1'b0;
            r_count  <= {CNT_W{1'b0}};
            r_busy   <= 1'b1;
          end
        end
        SHIFT: begin
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_res_sr <= w_res_next;
          r_borrow <= w_br_next;
          r_count  <= r_count + CNT_W'(1);
          if (w_last) begin
            r_difference <= w_res_next;
            r_borrow_out <= w_br_next;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
          end
        end
        DONE: begin
          r_done <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign difference = r_difference;
  assign borrow_out = r_borrow_out;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor. It computes difference = minuend - subtrahend with one full-subtractor cell (the borrow counterpart of the full-adder cell), processing one bit per clock, LSB first.
- Start/busy/done handshake.
- Sits beside the full-adder circuit as the inverse arithmetic unit. Intended for area-constrained datapaths and as a self-checking partner for adder benches: (a+b)-b == a.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- minuend  input  WIDTH  operand A; latched on accepted start.
- subtrahend  input  WIDTH  operand B; latched on accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; result valid.
- difference  output  WIDTH  (A - B) mod 2^WIDTH; held until next accepted start.
- borrow_out  output  1  final borrow; 1 iff A < B (unsigned).

Behaviour:
- Reset:
  - reset=1 at a rising edge forces state=IDLE, busy=0, done=0, difference=0, borrow_out=0.
  - Internal shift registers, borrow flop and bit counter are cleared.
  - reset takes priority over every other input, including mid-operation; any partial result is discarded.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: if start=1 at edge k, latch A and B into shift regs, set borrow=0, count=0, go to SHIFT; busy=1 from edge k. If start=0, stay in IDLE.
  - SHIFT: each edge processes bit a=A_sr[0], b=B_sr[0], br=borrow:
    - d = a^b^br
    - br_next = (~a&b) | (~(a^b)&br)
    - d shifts into the result MSB; A_sr and B_sr shift right; count increments.
    - On the edge processing bit WIDTH-1 (edge k+WIDTH), load difference from the completed result register, set borrow_out=br_next, go to DONE, busy=0, done=1.
  - DONE: lasts exactly one cycle with done=1, then returns to IDLE at edge k+WIDTH+1 and done=0.
- Latency: done is high during the cycle after edge k+WIDTH. A back-to-back start is accepted at earliest at edge k+WIDTH+2 (first edge in IDLE).
- start while busy=1 or in DONE is ignored, with no queuing. Operand inputs may change freely after the accepting edge.
- difference/borrow_out keep the previous result through a new operation and update only at the completing edge. They never show partial values.
- WIDTH=1: SHIFT lasts one cycle; done follows at edge k+1.
- Counter width is $clog2(WIDTH+1). The counter never wraps within an operation.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset then WIDTH=8, A=5, B=3, start pulse one cycle:
  - busy high for 8 cycles, then done one cycle.
  - difference=2, borrow_out=0.
  - done asserted exactly 9 edges after start edge counting the accept edge (i.e. after edge k+8).
- Boundary values:
  - A=3, B=5 -> difference=254, borrow_out=1.
  - A=0, B=1 -> 255, borrow_out=1.
  - A=255, B=255 -> 0, borrow_out=0.
  - A=0, B=0 -> 0, borrow_out=0.
- Start held high continuously with A=200, B=55:
  - First result 145/0 with done.
  - Next op accepted on first IDLE edge (k+10).
  - A and B changed during busy have no effect on the in-flight result.
  - Pulse spacing is 10 cycles.
- Reset asserted at SHIFT bit 4 of A=10, B=20:
  - Next edge busy=0, done=0, difference=0, borrow_out=0.
  - A following start with A=9, B=4 yields 5/0 with normal latency.
- Randomized self-check, ≥1000 ops, WIDTH=8 and WIDTH=1:
  - difference == (A-B) mod 2^WIDTH.
  - borrow_out == (A<B).
  - difference holds stable between done pulses.
